dpram_port_arbiter: RTL and testbench
=====================================

Name: dpram_port_arbiter

Overview:
- Shares one simple dual-port RAM between two requesters, A and B. The RAM has one read port (registered address, 1-cycle latency) and one write port.
- Read and write ports are arbitrated independently with per-port round-robin, so a read from one requester and a write from the other can both issue in the same cycle.
- Read data returns one cycle after grant, tagged to the requester that issued it.
- Sits between client logic and the Memory instance.

Parameters:
- DATA_WIDTH, 14, RAM word width
- ADDR_WIDTH, 6, RAM address width (depth 2**ADDR_WIDTH)

Ports:
- clk  in  1  single clock; all logic posedge
- rst  in  1  synchronous, active-high reset
- a_req_valid  in  1  requester A request present
- a_req_ready  out  1  A request accepted this cycle
- a_req_write  in  1  1 = write, 0 = read
- a_req_addr  in  ADDR_WIDTH  A address
- a_req_data  in  DATA_WIDTH  A write data
- a_rsp_valid  out  1  A read data valid
- a_rsp_data  out  DATA_WIDTH  A read data
- b_req_valid, b_req_ready, b_req_write, b_req_addr, b_req_data, b_rsp_valid, b_rsp_data: same as A, for requester B
- mem_rd_addr  out  ADDR_WIDTH  to RAM read port (RAM registers it)
- mem_rd_data  in  DATA_WIDTH  from RAM, valid the cycle after mem_rd_addr is sampled
- mem_wr_en  out  1  RAM write enable
- mem_wr_addr  out  ADDR_WIDTH  RAM write address
- mem_wr_data  out  DATA_WIDTH  RAM write data

Behaviour:
- Handshake: a request transfers on the cycle where req_valid & req_ready are both 1.
  - req_ready is combinational from the valids and the priority state.
  - Requesters hold addr/data/write stable while valid and not ready.
- Read arbitration: candidates are requesters with valid=1 and write=0.
  - One candidate: it is granted.
  - Two candidates: the one selected by rd_prio is granted, then rd_prio toggles to the other requester.
  - rd_prio changes only on a contested grant.
- Write arbitration: identical, with independent wr_prio; candidates have valid=1 and write=1.
- Reset: rst=1 at a posedge sets rd_prio = wr_prio = A and clears the response pipeline. While rst=1:
  - both req_ready = 0
  - mem_wr_en = 0
  - both rsp_valid = 0
- Read port:
  - mem_rd_addr = granted requester's address.
  - With no read grant, mem_rd_addr holds its previous value (register), so the RAM output is stable. Reset value 0.
- Write port:
  - mem_wr_en = 1 exactly in the cycle of a write grant.
  - mem_wr_addr/mem_wr_data = granted requester's fields; 0 when idle.
- Response pipeline:
  - A registered read-grant tag (valid + owner) is captured at the grant edge.
  - In the following cycle, owner's rsp_valid = 1 and rsp_data = mem_rd_data; the other requester's rsp_valid = 0.
  - rsp_data is 0 whenever its rsp_valid = 0.
  - Fixed latency 1 cycle; no backpressure on responses.
- Back-to-back: a requester may be granted reads on consecutive cycles; it then sees rsp_valid on consecutive cycles.
- Simultaneous read and write to the same address in the same cycle: the write lands at the same edge the read address is registered, so the read returns the NEW data (write-first). The block adds no bypass or stall.
- Reset mid-operation: a read granted in the cycle before rst rises gets no response. The tag is cleared at the reset edge and rsp_valid stays 0 in the following cycle.
- Fairness bound: under continuous contention on one port, each requester is granted at least every 2nd cycle.

Test Plan:
- Reset: hold rst 3 cycles with both valid=1 -> ready=0, mem_wr_en=0, rsp_valid=0 every cycle; first cycle after reset deasserts, A wins a contested read (rd_prio=A).
- Write then read: A writes addr 5 = 14'h1234, next cycle A reads addr 5 -> a_rsp_valid=1 one cycle after the read grant, a_rsp_data=14'h1234, b_rsp_valid=0.
- Parallel ports: same cycle, A reads addr 3 (holding 14'h0003), B writes addr 7 = 14'h0AAA -> both ready=1; mem_wr_en=1 with addr 7; next cycle a_rsp_data=14'h0003.
- Same-address collision: preload addr 9 = 14'h0111; A reads 9 while B writes 9 = 14'h2222 -> next cycle a_rsp_data=14'h2222.
- Round-robin: both hold read requests for 6 cycles -> grants A,B,A,B,A,B; rsp_valid alternates owner one cycle later with correct data. Repeat for writes with independent wr_prio.
- Reset mid-read: grant A read, assert rst the next edge -> a_rsp_valid stays 0; after release, a new read of addr 5 returns 14'h1234 (memory contents untouched by reset).

Source files
------------

// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter: shares one simple dual-port RAM between requesters A and B,
// with independent round-robin arbitration for the read and write ports.
module dpram_port_arbiter #(
    parameter int DATA_WIDTH = 14,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_req_write,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0] a_req_data,
    output logic                  a_rsp_valid,
    output logic [DATA_WIDTH-1:0] a_rsp_data,
    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic                  b_req_write,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [DATA_WIDTH-1:0] b_req_data,
    output logic                  b_rsp_valid,
    output logic [DATA_WIDTH-1:0] b_rsp_data,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data
);
    logic rd_cand_a, rd_cand_b, wr_cand_a, wr_cand_b;
    logic rd_gnt_a, rd_gnt_b, wr_gnt_a, wr_gnt_b;
    // Priority flags: 0 selects A, 1 selects B on the next contested grant.
    logic rd_prio_q, rd_prio_d, wr_prio_q, wr_prio_d;
    logic tag_vld_q, tag_vld_d, tag_b_q, tag_b_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q;

    always_comb begin
        rd_cand_a = ~rst & a_req_valid & ~a_req_write;
        rd_cand_b = ~rst & b_req_valid & ~b_req_write;
        wr_cand_a = ~rst & a_req_valid & a_req_write;
        wr_cand_b = ~rst & b_req_valid & b_req_write;
        rd_gnt_a  = rd_cand_a & (~rd_cand_b | ~rd_prio_q);
        rd_gnt_b  = rd_cand_b & (~rd_cand_a | rd_prio_q);
        wr_gnt_a  = wr_cand_a & (~wr_cand_b | ~wr_prio_q);
        wr_gnt_b  = wr_cand_b & (~wr_cand_a | wr_prio_q);
        rd_prio_d = (rd_cand_a & rd_cand_b) ? ~rd_prio_q : rd_prio_q;
        wr_prio_d = (wr_cand_a & wr_cand_b) ? ~wr_prio_q : wr_prio_q;
        tag_vld_d = rd_gnt_a | rd_gnt_b;
        tag_b_d   = rd_gnt_b;
    end

    assign a_req_ready = rd_gnt_a | wr_gnt_a;
    assign b_req_ready = rd_gnt_b | wr_gnt_b;
    // Hold the last granted read address so the RAM output stays stable when idle.
    assign mem_rd_addr = rd_gnt_a ? a_req_addr : rd_gnt_b ? b_req_addr : rd_addr_q;
    assign mem_wr_en   = wr_gnt_a | wr_gnt_b;
    assign mem_wr_addr = wr_gnt_a ? a_req_addr : wr_gnt_b ? b_req_addr : '0;
    assign mem_wr_data = wr_gnt_a ? a_req_data : wr_gnt_b ? b_req_data : '0;
    assign a_rsp_valid = ~rst & tag_vld_q & ~tag_b_q;
    assign b_rsp_valid = ~rst & tag_vld_q & tag_b_q;
    assign a_rsp_data  = a_rsp_valid ? mem_rd_data : '0;
    assign b_rsp_data  = b_rsp_valid ? mem_rd_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_prio_q <= 1'b0;
            wr_prio_q <= 1'b0;
            tag_vld_q <= 1'b0;
            tag_b_q   <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            rd_prio_q <= rd_prio_d;
            wr_prio_q <= wr_prio_d;
            tag_vld_q <= tag_vld_d;
            tag_b_q   <= tag_b_d;
            rd_addr_q <= mem_rd_addr;
        end
    end
endmodule

// File: tb/tb_dpram_port_arbiter.sv
// tb_dpram_port_arbiter: directed bench with a behavioural write-first RAM and a
// response scoreboard fed from a shadow copy of memory.
module tb_dpram_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        a_req_valid, a_req_ready, a_req_write, a_rsp_valid;
    logic [5:0]  a_req_addr;
    logic [13:0] a_req_data, a_rsp_data;
    logic        b_req_valid, b_req_ready, b_req_write, b_rsp_valid;
    logic [5:0]  b_req_addr;
    logic [13:0] b_req_data, b_rsp_data;
    logic [5:0]  mem_rd_addr, mem_wr_addr;
    logic [13:0] mem_rd_data, mem_wr_data;
    logic        mem_wr_en;

    typedef struct packed {
        logic        av;
        logic        bv;
        logic [13:0] d;
    } rsp_t;

    rsp_t        q[$];
    logic [13:0] ram [64] = '{default: 14'h0};
    logic [13:0] sm  [64] = '{default: 14'h0};
    logic [5:0]  last_rd = 6'h0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    dpram_port_arbiter #(.DATA_WIDTH(14), .ADDR_WIDTH(6)) dut (
        .clk(clk), .rst(rst),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_write(a_req_write),
        .a_req_addr(a_req_addr), .a_req_data(a_req_data),
        .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_write(b_req_write),
        .b_req_addr(b_req_addr), .b_req_data(b_req_data),
        .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
    );

    logic [13:0] rd_q;
    assign mem_rd_data = rd_q;
    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
        rd_q <= (mem_wr_en && mem_wr_addr == mem_rd_addr) ? mem_wr_data : ram[mem_rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check outputs, predict next-cycle response.
    task automatic cyc(input logic r,
                       input logic av, input logic aw, input logic [5:0] aa, input logic [13:0] ad,
                       input logic bv, input logic bw, input logic [5:0] ba, input logic [13:0] bd,
                       input logic ea, input logic eb);
        rsp_t e;
        logic rda, rdb, wra, wrb;
        logic [5:0] ra;
        rst = r;
        a_req_valid = av; a_req_write = aw; a_req_addr = aa; a_req_data = ad;
        b_req_valid = bv; b_req_write = bw; b_req_addr = ba; b_req_data = bd;
        #1;
        if (q.size() == 0) begin
            chk("scoreboard_empty", 32'(q.size()), 32'd1);
            e = '0;
        end else e = q.pop_front();
        if (r) e = '0;
        chk("a_rsp_valid", 32'(a_rsp_valid), 32'(e.av));
        chk("a_rsp_data", 32'(a_rsp_data), e.av ? 32'(e.d) : 32'd0);
        chk("b_rsp_valid", 32'(b_rsp_valid), 32'(e.bv));
        chk("b_rsp_data", 32'(b_rsp_data), e.bv ? 32'(e.d) : 32'd0);
        chk("a_req_ready", 32'(a_req_ready), 32'(ea));
        chk("b_req_ready", 32'(b_req_ready), 32'(eb));
        rda = ea & av & ~aw; rdb = eb & bv & ~bw;
        wra = ea & av & aw;  wrb = eb & bv & bw;
        chk("mem_wr_en", 32'(mem_wr_en), 32'(wra | wrb));
        chk("mem_wr_addr", 32'(mem_wr_addr), wra ? 32'(aa) : wrb ? 32'(ba) : 32'd0);
        chk("mem_wr_data", 32'(mem_wr_data), wra ? 32'(ad) : wrb ? 32'(bd) : 32'd0);
        ra = rda ? aa : rdb ? ba : last_rd;
        chk("mem_rd_addr", 32'(mem_rd_addr), 32'(ra));
        if (wra) sm[aa] = ad;
        if (wrb) sm[ba] = bd;
        e.av = rda; e.bv = rdb; e.d = (rda | rdb) ? sm[ra] : 14'h0;
        q.push_back(e);
        last_rd = r ? 6'h0 : ra;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        a_req_valid = 0; a_req_write = 0; a_req_addr = 0; a_req_data = 0;
        b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_data = 0;
        q.push_back('0);
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 6'd0, 14'h0, 1, 0, 6'd1, 14'h0, 0, 0);
        cyc(0, 1, 0, 6'd0, 14'h0, 1, 0, 6'd1, 14'h0, 1, 0);
        cyc(0, 1, 0, 6'd0, 14'h0, 1, 0, 6'd1, 14'h0, 0, 1);
        cyc(0, 1, 1, 6'd5, 14'h1234, 0, 0, 6'd0, 14'h0, 1, 0);
        cyc(0, 1, 0, 6'd5, 14'h0, 0, 0, 6'd0, 14'h0, 1, 0);
        cyc(0, 0, 0, 6'd0, 14'h0, 1, 1, 6'd3, 14'h0003, 0, 1);
        cyc(0, 1, 1, 6'd9, 14'h0111, 0, 0, 6'd0, 14'h0, 1, 0);
        cyc(0, 1, 0, 6'd3, 14'h0, 1, 1, 6'd7, 14'h0AAA, 1, 1);
        cyc(0, 1, 0, 6'd9, 14'h0, 1, 1, 6'd9, 14'h2222, 1, 1);
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 6'd5, 14'h0, 1, 0, 6'd7, 14'h0, i % 2 == 0, i % 2 == 1);
        for (int i = 0; i < 6; i++)
            cyc(0, 1, 1, 6'(10 + i), 14'(16'h0100 + i), 1, 1, 6'(20 + i), 14'(16'h0200 + i),
                i % 2 == 0, i % 2 == 1);
        cyc(0, 1, 0, 6'd11, 14'h0, 1, 0, 6'd20, 14'h0, 1, 0);
        cyc(0, 1, 0, 6'd3, 14'h0, 0, 0, 6'd0, 14'h0, 1, 0);
        cyc(0, 1, 0, 6'd5, 14'h0, 0, 0, 6'd0, 14'h0, 1, 0);
        cyc(0, 1, 0, 6'd7, 14'h0, 0, 0, 6'd0, 14'h0, 1, 0);
        cyc(1, 0, 0, 6'd0, 14'h0, 0, 0, 6'd0, 14'h0, 0, 0);
        cyc(1, 1, 1, 6'd5, 14'h3FFF, 1, 0, 6'd7, 14'h0, 0, 0);
        cyc(0, 0, 0, 6'd0, 14'h0, 0, 0, 6'd0, 14'h0, 0, 0);
        cyc(0, 1, 0, 6'd5, 14'h0, 1, 0, 6'd9, 14'h0, 1, 0);
        cyc(0, 0, 0, 6'd0, 14'h0, 1, 0, 6'd9, 14'h0, 0, 1);
        cyc(0, 0, 0, 6'd0, 14'h0, 0, 0, 6'd0, 14'h0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
